// File: rtl/exec_stage_pipe.sv
// ============================================================================
// exec_stage_pipe : registered execute stage (forwarding muxes, ALU, optional
// iterative multiplier enabled by macro EXEC_MUL_EN).  Rev 1.0
// ============================================================================
`default_nettype none

module exec_stage_pipe #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_op,
   input  logic [1:0]       src1_sel,
   input  logic [1:0]       src2_sel,
   input  logic             flag_src,
   input  logic [WIDTH-1:0] data1_val,
   input  logic [WIDTH-1:0] data2_val,
   input  logic [WIDTH-1:0] imm_val,
   input  logic [WIDTH-1:0] prev_mem,
   input  logic [3:0]       flags_in,
   input  logic [3:0]       mem_flags,
   output logic [WIDTH-1:0] alu_out,
   output logic [3:0]       flags_out,
   output logic             out_valid,
   output logic             busy
);

   localparam logic [2:0] OP_MOV = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   logic [WIDTH-1:0] alu_out_q, alu_out_d;
   logic [3:0]       flags_q, flags_d;
   logic             out_valid_q, out_valid_d;

   logic [WIDTH-1:0] op1, op2, res;
   logic [WIDTH:0]   sum_ext, diff_ext, shl_ext;
   logic             c_new, v_new;
   logic [3:0]       alu_flags, sel_flags;
   logic             accept;

   always_comb begin
      case (src1_sel)
         2'b00:   op1 = data1_val;
         2'b01:   op1 = alu_out_q;
         2'b10:   op1 = prev_mem;
         default: op1 = data2_val;
      endcase
      case (src2_sel)
         2'b00:   op2 = data2_val;
         2'b01:   op2 = alu_out_q;
         2'b10:   op2 = prev_mem;
         default: op2 = imm_val;
      endcase
   end

   always_comb begin
      res      = '0;
      c_new    = flags_in[2];
      v_new    = flags_in[3];
      sum_ext  = {1'b0, op1} + {1'b0, op2};
      diff_ext = {1'b0, op1} - {1'b0, op2};
      // Bit WIDTH of the widened shift is the last bit pushed out (0 for a zero shift).
      shl_ext  = {1'b0, op1} << op2[CNT_W-1:0];
      case (alu_op)
         OP_MOV: res = op2;
         OP_ADD: begin
            res   = sum_ext[WIDTH-1:0];
            c_new = sum_ext[WIDTH];
            v_new = (op1[WIDTH-1] == op2[WIDTH-1]) && (res[WIDTH-1] != op1[WIDTH-1]);
         end
         OP_SUB: begin
            res   = diff_ext[WIDTH-1:0];
            c_new = diff_ext[WIDTH];
            v_new = (op1[WIDTH-1] != op2[WIDTH-1]) && (res[WIDTH-1] != op1[WIDTH-1]);
         end
         OP_AND: res = op1 & op2;
         OP_OR:  res = op1 | op2;
         OP_NOT: res = ~op1;
         OP_SHL: begin
            res   = shl_ext[WIDTH-1:0];
            c_new = shl_ext[WIDTH];
         end
         default: res = '0;
      endcase
      alu_flags = {v_new, c_new, res[WIDTH-1], ~|res};
`ifndef EXEC_MUL_EN
      if (alu_op == OP_MUL) begin
         alu_flags = flags_in;
      end
`endif
      sel_flags = flag_src ? alu_flags : mem_flags;
   end

`ifdef EXEC_MUL_EN
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic               mul_fsrc_q, mul_fsrc_d;
   logic [3:0]         mul_mflags_q, mul_mflags_d;
   logic [2*WIDTH-1:0] acc_step;
   logic [3:0]         mul_flags;

   assign busy     = (state_q == ST_MUL);
   assign in_ready = ~busy;
   assign accept   = in_valid & in_ready & ~flush;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      mul_fsrc_d   = mul_fsrc_q;
      mul_mflags_d = mul_mflags_q;
      alu_out_d    = alu_out_q;
      flags_d      = flags_q;
      out_valid_d  = 1'b0;
      acc_step     = acc_q + (mplier_q[0] ? mcand_q : '0);
      mul_flags    = {1'b0, |acc_step[2*WIDTH-1:WIDTH], acc_step[WIDTH-1],
                      ~|acc_step[WIDTH-1:0]};
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (alu_op == OP_MUL) begin
                  // Bit 0 is folded into the accept edge so the result lands
                  // WIDTH cycles after issue with only WIDTH-1 busy cycles.
                  acc_d        = op2[0] ? {{WIDTH{1'b0}}, op1} : '0;
                  mcand_d      = {{(WIDTH-1){1'b0}}, op1, 1'b0};
                  mplier_d     = op2 >> 1;
                  cnt_d        = CNT_W'(1);
                  mul_fsrc_d   = flag_src;
                  mul_mflags_d = mem_flags;
                  state_d      = ST_MUL;
               end else begin
                  alu_out_d   = res;
                  flags_d     = sel_flags;
                  out_valid_d = 1'b1;
               end
            end
         end
         ST_MUL: begin
            if (flush) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               acc_d   = '0;
            end else begin
               acc_d    = acc_step;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH-1)) begin
                  alu_out_d   = acc_step[WIDTH-1:0];
                  flags_d     = mul_fsrc_q ? mul_flags : mul_mflags_q;
                  out_valid_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         acc_q        <= '0;
         mcand_q      <= '0;
         mplier_q     <= '0;
         mul_fsrc_q   <= 1'b0;
         mul_mflags_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         mcand_q      <= mcand_d;
         mplier_q     <= mplier_d;
         mul_fsrc_q   <= mul_fsrc_d;
         mul_mflags_q <= mul_mflags_d;
      end
   end
`else
   assign busy     = 1'b0;
   assign in_ready = 1'b1;
   assign accept   = in_valid & ~flush;

   always_comb begin
      alu_out_d   = alu_out_q;
      flags_d     = flags_q;
      out_valid_d = 1'b0;
      if (accept) begin
         alu_out_d   = res;
         flags_d     = sel_flags;
         out_valid_d = 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_out_q   <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         alu_out_q   <= alu_out_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign alu_out   = alu_out_q;
   assign flags_out = flags_q;
   assign out_valid = out_valid_q;

endmodule

`default_nettype wire
